// File: rtl/pipe_adder.sv
// Segmented, pipelined carry-ripple adder/subtractor with valid/ready streaming.
// One SEG_W-bit slice of the sum is produced per stage; the carry rides between stages.
module pipe_adder #(
    parameter int WIDTH = 16,
    parameter int SEG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSEG = WIDTH / SEG_W;

    // Reject geometries that cannot be split into whole segments.
    if (SEG_W < 1) begin : g_bad_seg
        $error("pipe_adder: SEG_W must be >= 1");
    end else if ((WIDTH % SEG_W) != 0) begin : g_bad_width
        $error("pipe_adder: WIDTH must be a multiple of SEG_W");
    end

    // Stage registers: r_q holds finished low segments plus still-unadded
    // high segments of A; b_q carries B' (already inverted for subtract).
    logic             v_q  [NSEG];
    logic             c_q  [NSEG];
    logic             as_q [NSEG];
    logic             bs_q [NSEG];
    logic [WIDTH-1:0] r_q  [NSEG];
    logic [WIDTH-1:0] b_q  [NSEG];

    logic             c_d  [NSEG];
    logic [WIDTH-1:0] r_d  [NSEG];

    logic             up_v  [NSEG];
    logic             up_c  [NSEG];
    logic             up_as [NSEG];
    logic             up_bs [NSEG];
    logic [WIDTH-1:0] up_r  [NSEG];
    logic [WIDTH-1:0] up_b  [NSEG];

    logic             rdy [NSEG+1];

    // Select what each stage would load: the inputs for stage 0,
    // otherwise the previous stage's register.
    always_comb begin
        up_v[0]  = in_valid;
        up_c[0]  = sub | cin;
        up_r[0]  = a;
        up_b[0]  = sub ? ~b : b;
        up_as[0] = a[WIDTH-1];
        up_bs[0] = sub ? ~b[WIDTH-1] : b[WIDTH-1];
        for (int k = 1; k < NSEG; k++) begin
            up_v[k]  = v_q[k-1];
            up_c[k]  = c_q[k-1];
            up_r[k]  = r_q[k-1];
            up_b[k]  = b_q[k-1];
            up_as[k] = as_q[k-1];
            up_bs[k] = bs_q[k-1];
        end
    end

    // Add segment k of the incoming word and splice it into the result.
    always_comb begin
        logic [SEG_W:0] seg;
        seg = '0;
        for (int k = 0; k < NSEG; k++) begin
            seg = {1'b0, up_r[k][k*SEG_W +: SEG_W]}
                + {1'b0, up_b[k][k*SEG_W +: SEG_W]}
                + {{SEG_W{1'b0}}, up_c[k]};
            r_d[k] = up_r[k];
            r_d[k][k*SEG_W +: SEG_W] = seg[SEG_W-1:0];
            c_d[k] = seg[SEG_W];
        end
    end

    // Ready ripples back from the sink; an empty stage always accepts.
    always_comb begin
        rdy[NSEG] = out_ready;
        for (int k = NSEG - 1; k >= 0; k--) begin
            rdy[k] = !v_q[k] | rdy[k+1];
        end
    end

    // Stage registers advance only when their own ready is high.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NSEG; k++) begin
            if (!rst_n) begin
                v_q[k]  <= 1'b0;
                c_q[k]  <= 1'b0;
                as_q[k] <= 1'b0;
                bs_q[k] <= 1'b0;
                r_q[k]  <= '0;
                b_q[k]  <= '0;
            end else if (rdy[k]) begin
                v_q[k]  <= up_v[k];
                c_q[k]  <= c_d[k];
                as_q[k] <= up_as[k];
                bs_q[k] <= up_bs[k];
                r_q[k]  <= r_d[k];
                b_q[k]  <= up_b[k];
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[NSEG-1];
    assign sum       = r_q[NSEG-1];
    assign cout      = c_q[NSEG-1];
    assign ovf       = (as_q[NSEG-1] == bs_q[NSEG-1])
                     & (r_q[NSEG-1][WIDTH-1] != as_q[NSEG-1]);

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder (WIDTH=16, SEG_W=4, four stages).
// Each scenario task drives its own stimulus and checks results inline.
module tb_pipe_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int total = 0;
    int bad   = 0;

    logic [17:0] q[$];

    always #5 clk = ~clk;

    pipe_adder #(
        .WIDTH(16),
        .SEG_W(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    // Reference: {sum, cout, ovf} from plain 17-bit arithmetic.
    function automatic logic [17:0] model(input logic [15:0] ma,
                                          input logic [15:0] mb,
                                          input logic mc,
                                          input logic ms);
        logic [15:0] bp;
        logic [16:0] t;
        logic        ov;
        bp = ms ? ~mb : mb;
        t  = {1'b0, ma} + {1'b0, bp} + {16'd0, (ms ? 1'b1 : mc)};
        ov = (ma[15] == bp[15]) && (t[15] != ma[15]);
        return {t[15:0], t[16], ov};
    endfunction

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({out_valid, sum, cout, ovf} !== 19'd0) begin
            bad++;
            $display("FAIL reset_outputs: got v=%b sum=%h c=%b o=%b want 0",
                     out_valid, sum, cout, ovf);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [15:0] va [8] = '{16'h00FF, 16'hFFFF, 16'h8000, 16'h0003,
                                16'h7FFF, 16'h0005, 16'h1234, 16'h0FFF};
        logic [15:0] vb [8] = '{16'h0001, 16'h0000, 16'h0001, 16'h0005,
                                16'h0001, 16'h0003, 16'h4321, 16'h0001};
        logic        vc [8] = '{1'b0, 1'b1, 1'b0, 1'b0,
                                1'b0, 1'b1, 1'b0, 1'b0};
        logic        vs [8] = '{1'b0, 1'b0, 1'b1, 1'b1,
                                1'b0, 1'b1, 1'b0, 1'b0};
        logic [17:0] ve [8] = '{{16'h0100, 1'b0, 1'b0},
                                {16'h0000, 1'b1, 1'b0},
                                {16'h7FFF, 1'b1, 1'b1},
                                {16'hFFFE, 1'b0, 1'b0},
                                {16'h8000, 1'b0, 1'b1},
                                {16'h0002, 1'b1, 1'b0},
                                {16'h5555, 1'b0, 1'b0},
                                {16'h1000, 1'b0, 1'b0}};
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a = va[i]; b = vb[i]; cin = vc[i]; sub = vs[i];
            in_valid = 1'b1;
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL basic_in_ready[%0d]: got %b want 1", i, in_ready);
            end
            @(posedge clk);
            #1 in_valid = 1'b0;
            lat = 0;
            while (out_valid !== 1'b1 && lat < 20) begin
                @(posedge clk);
                #1;
                lat++;
            end
            total++;
            if (lat != 3) begin
                bad++;
                $display("FAIL basic_latency[%0d]: got %0d edges want 3", i, lat);
            end
            total++;
            if ({sum, cout, ovf} !== ve[i]) begin
                bad++;
                $display("FAIL basic_result[%0d]: got %h/%b/%b want %h/%b/%b",
                         i, sum, cout, ovf, ve[i][17:2], ve[i][1], ve[i][0]);
            end
            @(posedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] e;
        logic        want_v;
        int          got = 0;
        q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 110; i++) begin
            @(negedge clk);
            want_v = (i >= 4) && (i < 104);
            total++;
            if (out_valid !== want_v) begin
                bad++;
                $display("FAIL stream_valid[%0d]: got %b want %b", i, out_valid, want_v);
            end
            if (out_valid === 1'b1 && q.size() > 0) begin
                e = q.pop_front();
                got++;
                total++;
                if ({sum, cout, ovf} !== e) begin
                    bad++;
                    $display("FAIL stream_data[%0d]: got %h/%b/%b want %h/%b/%b",
                             got, sum, cout, ovf, e[17:2], e[1], e[0]);
                end
            end
            if (i < 100) begin
                a   = 16'($urandom);
                b   = 16'($urandom);
                cin = 1'($urandom_range(1));
                sub = 1'($urandom_range(1));
                in_valid = 1'b1;
                q.push_back(model(a, b, cin, sub));
            end else begin
                in_valid = 1'b0;
            end
        end
        total++;
        if (got != 100 || q.size() != 0) begin
            bad++;
            $display("FAIL stream_count: got %0d results want 100", got);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] hs = '0;
        logic        held = 1'b0;
        logic [17:0] e;
        int          acc = 0;
        int          got = 0;
        q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (!held) begin
                    hs   = sum;
                    held = 1'b1;
                    total++;
                    if ({sum, cout, ovf} !== q[0]) begin
                        bad++;
                        $display("FAIL bp_head: got %h want %h", sum, q[0][17:2]);
                    end
                end else begin
                    total++;
                    if (sum !== hs) begin
                        bad++;
                        $display("FAIL bp_stable[%0d]: got %h want %h", i, sum, hs);
                    end
                end
            end
            a   = 16'h1000 + 16'(acc) * 16'h0111;
            b   = 16'h0F0F ^ 16'(acc);
            cin = 1'b1;
            sub = acc[0];
            in_valid = 1'b1;
            #1;
            if (in_ready === 1'b1) begin
                q.push_back(model(a, b, cin, sub));
                acc++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (acc != 4) begin
            bad++;
            $display("FAIL bp_accepted: got %0d want 4", acc);
        end
        total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL bp_full: got in_ready=%b out_valid=%b want 0/1",
                     in_ready, out_valid);
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_ripple_ready: got %b want 1", in_ready);
        end
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            if (out_valid === 1'b1) begin
                got++;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL bp_extra: got extra result %h want none", sum);
                end else begin
                    e = q.pop_front();
                    total++;
                    if ({sum, cout, ovf} !== e) begin
                        bad++;
                        $display("FAIL bp_drain[%0d]: got %h/%b/%b want %h/%b/%b",
                                 got, sum, cout, ovf, e[17:2], e[1], e[0]);
                    end
                end
            end
        end
        total++;
        if (got != 4) begin
            bad++;
            $display("FAIL bp_drain_count: got %0d want 4", got);
        end
    endtask

    task automatic test_reset_midflight();
        int seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 16'h0101 * 16'(i + 1); b = 16'h0011; cin = 1'b0; sub = 1'b0;
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if ({out_valid, sum, cout, ovf} !== 19'd0) begin
            bad++;
            $display("FAIL midreset_outputs: got v=%b sum=%h c=%b o=%b want 0",
                     out_valid, sum, cout, ovf);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midreset_in_ready: got %b want 1", in_ready);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL midreset_stale: got %0d stale results want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
